slurm32_cpu_mem_arbiter: RTL and testbench
==========================================

// Module: slurm32_cpu_mem_arbiter
// PURPOSE
//  Shares the single CPU memory port between instruction fetch and the stage-4 load/store
//  unit of slurm32_cpu_pipeline. Drives the fetch valid and memory-done handshakes back to
//  the pipeline, one transaction outstanding at a time. Data requests beat fetches by default.
// PARAMETERS
//  BITS          32  data width
//  ADDRESS_BITS  32  byte address width; addr[1:0] forced to 0 on mem_addr
//  STARVE_LIMIT  4   consecutive data grants before a pending fetch is forced (fair mode only)
// PORTS
//  CLK        in   1    clock, all state on posedge
//  RSTb       in   1    asynchronous, active-low reset
//  ins_req    in   1    fetch request, level, held until ins_valid or ins_abort
//  ins_addr   in   AB   fetch address
//  ins_abort  in   1    pipeline flush/branch: drop any in-flight fetch result
//  ins_valid  out  1    1-cycle pulse: ins_data holds fetched word
//  ins_data   out  BITS fetched instruction
//  dat_req    in   1    stage-4 load/store request, level
//  dat_wr     in   1    1 = store, 0 = load
//  dat_addr   in   AB   data address
//  dat_wdata  in   BITS store data
//  dat_be     in   4    byte enables
//  dat_done   out  1    1-cycle pulse: load data valid / store committed
//  dat_rdata  out  BITS load data
//  mem_req    out  1    bus request, held with stable fields until mem_ack
//  mem_wr     out  1    bus write strobe qualifier
//  mem_addr   out  AB   bus address
//  mem_wdata  out  BITS bus write data
//  mem_be     out  4    bus byte enables
//  mem_ack    in   1    bus accepted request this cycle
//  mem_rvalid in   1    read data valid on mem_rdata (>=1 cycle after mem_ack)
//  mem_rdata  in   BITS bus read data
//  busy       out  1    high in any state but IDLE
// BEHAVIOUR
//  Reset: state IDLE; mem_req, mem_wr, ins_valid, dat_done, busy = 0; data/addr regs = 0;
//   starve counter = 0. Reset asserted mid-transaction drops it silently, no pulses.
//  States: IDLE, INS_RD, DAT_RD, DAT_WR.
//  IDLE: sample requests. dat_req -> latch dat_* onto mem_*, mem_req=1, go DAT_RD/DAT_WR.
//   else ins_req && !ins_abort -> latch ins_addr, mem_req=1, mem_wr=0, be=4'hf, go INS_RD.
//   Request fields are captured at issue; later input changes are ignored.
//  mem_req drops the cycle after mem_ack is seen; fields stable while mem_req && !mem_ack.
//  INS_RD: on mem_rvalid register mem_rdata->ins_data, pulse ins_valid next cycle unless
//   abort seen at any point since issue (sticky abort flag, cleared on return to IDLE).
//  DAT_RD: on mem_rvalid register ->dat_rdata, pulse dat_done next cycle. Never aborted.
//  DAT_WR: dat_done pulses the cycle after mem_ack; mem_rvalid ignored.
//  Completion returns to IDLE; a new issue occurs earliest the cycle after the done pulse
//   (min 3-cycle turnaround with 0-wait ack and 1-cycle rvalid).
//  mem_rvalid before mem_ack, or in IDLE: ignored. ins_abort with no fetch in flight: no-op.
//  Simultaneous ins_req and dat_req in IDLE: data wins (strict mode).
// CONFIGURATION
//  SLURM32_MEM_ARB_FAIR_EN defined: 3-bit starve counter increments on each data grant made
//   while ins_req pending; at STARVE_LIMIT next IDLE grant goes to fetch, counter -> 0.
//   Counter also clears on any fetch grant. Saturates, never wraps.
//  Undefined: strict data priority; counter logic absent; fetch may starve indefinitely.
// TESTING
//  1 ins_req addr 0x100, ack same cycle, rvalid +1 with 0xDEADBEEF -> ins_valid 1 pulse, data 0xDEADBEEF.
//  2 ins_req+dat_req(load 0x2000) same cycle -> mem_addr 0x2000 first, dat_done, then fetch issued.
//  3 store 0x3004 data 0x12345678 be 4'h3, ack delayed 3 cycles -> mem_* stable 4 cycles, dat_done 1 after ack.
//  4 fetch in flight, ins_abort 1 cycle before rvalid -> no ins_valid, busy low, next fetch issues.
//  5 RSTb low during DAT_RD -> mem_req=0, busy=0 immediately; no dat_done after release.
//  6 FAIR_EN, STARVE_LIMIT=4, dat_req held, ins_req held -> grants D,D,D,D,I,D...

Source files
------------

// File: rtl/slurm32_cpu_mem_arbiter_if.sv
// slurm32_cpu_mem_arbiter_if: single CPU memory port shared by fetch and load/store.
// master = arbiter side, slave = memory side.
interface slurm32_cpu_mem_arbiter_if #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 32
);
  logic                    mem_req;
  logic                    mem_wr;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [BITS-1:0]         mem_wdata;
  logic [3:0]              mem_be;
  logic                    mem_ack;
  logic                    mem_rvalid;
  logic [BITS-1:0]         mem_rdata;

  modport master (
    output mem_req,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ack,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ack,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/slurm32_cpu_mem_arbiter.sv
// slurm32_cpu_mem_arbiter: fetch vs load/store arbiter, one access in flight.
// Define SLURM32_MEM_ARB_FAIR_EN to bound fetch starvation by STARVE_LIMIT.
module slurm32_cpu_mem_arbiter #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      CLK,
  input  logic                      RSTb,
  input  logic                      ins_req,
  input  logic [ADDRESS_BITS-1:0]   ins_addr,
  input  logic                      ins_abort,
  output logic                      ins_valid,
  output logic [BITS-1:0]           ins_data,
  input  logic                      dat_req,
  input  logic                      dat_wr,
  input  logic [ADDRESS_BITS-1:0]   dat_addr,
  input  logic [BITS-1:0]           dat_wdata,
  input  logic [3:0]                dat_be,
  output logic                      dat_done,
  output logic [BITS-1:0]           dat_rdata,
  slurm32_cpu_mem_arbiter_if.master mem,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE,
    INS_RD,
    DAT_RD,
    DAT_WR
  } state_t;

  localparam int AB = ADDRESS_BITS;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must fit the 3-bit starve counter (1..7)");
  end

  state_t          state_q;
  state_t          state_d;
  logic            req_q;
  logic            wr_q;
  logic [AB-1:0]   addr_q;
  logic [BITS-1:0] wdata_q;
  logic [3:0]      be_q;
  logic            abort_q;
  logic            grant_ins;
  logic            grant_dat;
  logic            starved;
  logic            can_issue;
  logic            rd_beat;
  logic            wr_beat;
  logic [3:0]      unused_addr_lsb;

  assign unused_addr_lsb = {ins_addr[1:0], dat_addr[1:0]};

  // Hold off issue during a done pulse: the requester still sees its old level.
  assign can_issue = !(ins_valid || dat_done);
  assign rd_beat   = !req_q && mem.mem_rvalid;
  assign wr_beat   = req_q && mem.mem_ack;

`ifdef SLURM32_MEM_ARB_FAIR_EN
  logic [2:0] starve_q;

  assign starved = starve_q >= 3'(STARVE_LIMIT);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      starve_q <= '0;
    end else if (grant_ins) begin
      starve_q <= '0;
    end else if (grant_dat && ins_req && starve_q != 3'h7) begin
      starve_q <= starve_q + 3'd1;
    end
  end
`else
  assign starved = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_ins = 1'b0;
    grant_dat = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_issue) begin
          if (ins_req && !ins_abort && starved) begin
            grant_ins = 1'b1;
          end else if (dat_req) begin
            grant_dat = 1'b1;
          end else if (ins_req && !ins_abort) begin
            grant_ins = 1'b1;
          end
        end
        if (grant_ins) begin
          state_d = INS_RD;
        end else if (grant_dat) begin
          state_d = dat_wr ? DAT_WR : DAT_RD;
        end
      end
      INS_RD: if (rd_beat) state_d = IDLE;
      DAT_RD: if (rd_beat) state_d = IDLE;
      DAT_WR: if (wr_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      abort_q   <= 1'b0;
      ins_valid <= 1'b0;
      ins_data  <= '0;
      dat_done  <= 1'b0;
      dat_rdata <= '0;
    end else begin
      ins_valid <= 1'b0;
      dat_done  <= 1'b0;
      if (req_q && mem.mem_ack) begin
        req_q <= 1'b0;
      end
      if (grant_dat) begin
        req_q   <= 1'b1;
        wr_q    <= dat_wr;
        addr_q  <= {dat_addr[AB-1:2], 2'b00};
        wdata_q <= dat_wdata;
        be_q    <= dat_be;
      end
      if (grant_ins) begin
        req_q   <= 1'b1;
        wr_q    <= 1'b0;
        addr_q  <= {ins_addr[AB-1:2], 2'b00};
        wdata_q <= '0;
        be_q    <= 4'hf;
      end
      if (state_q == IDLE) begin
        abort_q <= 1'b0;
      end else if (state_q == INS_RD && ins_abort) begin
        abort_q <= 1'b1;
      end
      if (state_q == INS_RD && rd_beat) begin
        ins_data  <= mem.mem_rdata;
        ins_valid <= !(abort_q || ins_abort);
      end
      if (state_q == DAT_RD && rd_beat) begin
        dat_rdata <= mem.mem_rdata;
        dat_done  <= 1'b1;
      end
      if (state_q == DAT_WR && wr_beat) begin
        dat_done <= 1'b1;
      end
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_wr    = wr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign busy          = state_q != IDLE;

endmodule

// File: tb/tb_slurm32_cpu_mem_arbiter.sv
// tb_slurm32_cpu_mem_arbiter: scoreboard bench with a memory responder.
// Build with SLURM32_MEM_ARB_FAIR_EN to match a fair-mode DUT.
module tb_slurm32_cpu_mem_arbiter;
  localparam int BITS = 32;
  localparam int AB   = 32;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } grant_t;

  typedef struct {
    logic        store;
    logic [31:0] data;
  } rsp_t;

  logic            CLK = 1'b0;
  logic            RSTb = 1'b0;
  logic            ins_req = 1'b0;
  logic [AB-1:0]   ins_addr = '0;
  logic            ins_abort = 1'b0;
  logic            ins_valid;
  logic [BITS-1:0] ins_data;
  logic            dat_req = 1'b0;
  logic            dat_wr = 1'b0;
  logic [AB-1:0]   dat_addr = '0;
  logic [BITS-1:0] dat_wdata = '0;
  logic [3:0]      dat_be = '0;
  logic            dat_done;
  logic [BITS-1:0] dat_rdata;
  logic            busy;

  slurm32_cpu_mem_arbiter_if #(.BITS(BITS), .ADDRESS_BITS(AB)) mem ();

  slurm32_cpu_mem_arbiter #(
    .BITS(BITS), .ADDRESS_BITS(AB), .STARVE_LIMIT(4)
  ) dut (
    .CLK(CLK), .RSTb(RSTb),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_abort(ins_abort),
    .ins_valid(ins_valid), .ins_data(ins_data),
    .dat_req(dat_req), .dat_wr(dat_wr), .dat_addr(dat_addr),
    .dat_wdata(dat_wdata), .dat_be(dat_be),
    .dat_done(dat_done), .dat_rdata(dat_rdata),
    .mem(mem.master), .busy(busy)
  );

  always #5 CLK = ~CLK;

  grant_t exp_g[$];
  rsp_t   exp_i[$];
  rsp_t   exp_d[$];
  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int rv_cyc = 0;
  int ack_wait = 0;
  int rv_lat = 1;
  int wait_cnt = 0;
  int rd_cnt = 0;
  int acks = 0;
  int iv_cnt = 0;
  int dd_cnt = 0;
  int stop_cnt = 0;
  int dat_stop_after = 0;
  bit acked = 0;
  bit dat_auto_drop = 1;
  bit rd_fixed_en = 0;
  logic [31:0] rd_fixed = '0;
  logic [31:0] rd_data = '0;
  logic [31:0] stop_addr = 32'h40;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a);
    exp_g.push_back('{1'b0, {a[31:2], 2'b00}, 32'h0, 4'hf});
    exp_i.push_back('{1'b0, mem_model({a[31:2], 2'b00})});
  endtask

  task automatic push_load(input logic [31:0] a, input logic [3:0] be);
    exp_g.push_back('{1'b0, {a[31:2], 2'b00}, 32'h0, be});
    exp_d.push_back('{1'b0, mem_model({a[31:2], 2'b00})});
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    exp_g.push_back('{1'b1, {a[31:2], 2'b00}, d, be});
    exp_d.push_back('{1'b1, 32'h0});
  endtask

  task automatic drain(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (exp_g.size() == 0 && exp_i.size() == 0 && exp_d.size() == 0 &&
          !busy && !ins_req && !dat_req) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Output monitor first, then memory responder, once per falling edge.
  initial begin
    grant_t g;
    rsp_t r;
    mem.mem_ack = 1'b0;
    mem.mem_rvalid = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (ins_valid) begin
        iv_cnt++;
        nvec++;
        if (exp_i.size() == 0) begin
          nfail++;
          $display("FAIL ins_valid_unexpected: got data=%h, required no pulse", ins_data);
        end else begin
          r = exp_i.pop_front();
          if (ins_data !== r.data || cyc != rv_cyc + 1) begin
            nfail++;
            $display("FAIL ins_data: got %h lat=%0d, required %h lat=1",
                     ins_data, cyc - rv_cyc, r.data);
          end
        end
        ins_req = 1'b0;
      end
      if (dat_done) begin
        dd_cnt++;
        nvec++;
        if (exp_d.size() == 0) begin
          nfail++;
          $display("FAIL dat_done_unexpected: got rdata=%h, required no pulse", dat_rdata);
        end else begin
          r = exp_d.pop_front();
          if (r.store) begin
            if (cyc != ack_cyc + 1) begin
              nfail++;
              $display("FAIL store_done_lat: got %0d, required 1", cyc - ack_cyc);
            end
          end else if (dat_rdata !== r.data || cyc != rv_cyc + 1) begin
            nfail++;
            $display("FAIL dat_rdata: got %h lat=%0d, required %h lat=1",
                     dat_rdata, cyc - rv_cyc, r.data);
          end
        end
        if (dat_auto_drop) dat_req = 1'b0;
      end
      mem.mem_ack = 1'b0;
      mem.mem_rvalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem.mem_rvalid = 1'b1;
          mem.mem_rdata = rd_data;
          rv_cyc = cyc;
        end
      end
      if (!mem.mem_req) begin
        acked = 0;
        wait_cnt = 0;
      end else if (!acked) begin
        nvec++;
        if (exp_g.size() == 0) begin
          nfail++;
          $display("FAIL grant_unexpected: got addr=%h wr=%b, required none",
                   mem.mem_addr, mem.mem_wr);
        end else begin
          g = exp_g[0];
          if (mem.mem_wr !== g.wr || mem.mem_addr !== g.addr ||
              mem.mem_be !== g.be || (g.wr && mem.mem_wdata !== g.wdata)) begin
            nfail++;
            $display("FAIL grant_fields: got wr=%b a=%h d=%h be=%h, required wr=%b a=%h d=%h be=%h",
                     mem.mem_wr, mem.mem_addr, mem.mem_wdata, mem.mem_be,
                     g.wr, g.addr, g.wdata, g.be);
          end
        end
        if (wait_cnt == ack_wait) begin
          mem.mem_ack = 1'b1;
          acked = 1;
          acks++;
          ack_cyc = cyc;
          if (exp_g.size() != 0) void'(exp_g.pop_front());
          if (!mem.mem_wr) begin
            rd_cnt = rv_lat;
            rd_data = rd_fixed_en ? rd_fixed : mem_model(mem.mem_addr);
            if (mem.mem_addr == stop_addr) begin
              stop_cnt++;
              if (dat_stop_after > 0 && stop_cnt == dat_stop_after) dat_req = 1'b0;
            end
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic test_reset();
    tick();
    tick();
    nvec++;
    if (mem.mem_req !== 1'b0 || mem.mem_wr !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_ctrl: got req=%b wr=%b busy=%b, required 0 0 0",
               mem.mem_req, mem.mem_wr, busy);
    end
    nvec++;
    if (ins_valid !== 1'b0 || dat_done !== 1'b0) begin
      nfail++;
      $display("FAIL reset_pulses: got iv=%b dd=%b, required 0 0", ins_valid, dat_done);
    end
    nvec++;
    if (mem.mem_addr !== '0 || ins_data !== '0 || dat_rdata !== '0) begin
      nfail++;
      $display("FAIL reset_regs: got a=%h id=%h dr=%h, required 0", mem.mem_addr,
               ins_data, dat_rdata);
    end
    RSTb = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bit ok;
    rd_fixed_en = 1;
    rd_fixed = 32'hDEAD_BEEF;
    exp_g.push_back('{1'b0, 32'h100, 32'h0, 4'hf});
    exp_i.push_back('{1'b0, 32'hDEAD_BEEF});
    ins_addr = 32'h100;
    ins_req = 1'b1;
    drain(40, ok);
    rd_fixed_en = 0;
    nvec++;
    if (!ok) begin
      nfail++;
      $display("FAIL fetch_drain: got busy=%b pend=%0d, required idle", busy, exp_i.size());
    end
  endtask

  task automatic test_priority();
    bit ok;
    push_load(32'h2000, 4'hf);
    push_fetch(32'h800);
    ins_addr = 32'h800;
    dat_addr = 32'h2000;
    dat_wr = 1'b0;
    dat_be = 4'hf;
    ins_req = 1'b1;
    dat_req = 1'b1;
    drain(60, ok);
    nvec++;
    if (!ok) begin
      nfail++;
      $display("FAIL priority_drain: got pend g=%0d i=%0d d=%0d, required 0",
               exp_g.size(), exp_i.size(), exp_d.size());
    end
  endtask

  task automatic test_store_wait();
    bit ok;
    int hi;
    hi = 0;
    ack_wait = 3;
    push_store(32'h3004, 32'h1234_5678, 4'h3);
    dat_addr = 32'h3004;
    dat_wdata = 32'h1234_5678;
    dat_be = 4'h3;
    dat_wr = 1'b1;
    dat_req = 1'b1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mem.mem_req) hi++;
      if (busy) begin
        dat_addr = 32'hFFFF_FFF0;
        dat_wdata = 32'h0;
        dat_be = 4'hc;
      end
      if (!busy && exp_d.size() == 0 && !dat_req) begin
        ok = 1;
        break;
      end
    end
    ack_wait = 0;
    dat_wr = 1'b0;
    nvec++;
    if (!ok || hi != 4) begin
      nfail++;
      $display("FAIL store_req_cycles: got %0d done=%b, required 4 done=1", hi, ok);
    end
  endtask

  task automatic test_abort();
    bit ok;
    int a0;
    int iv0;
    rv_lat = 3;
    a0 = acks;
    iv0 = iv_cnt;
    exp_g.push_back('{1'b0, 32'h200, 32'h0, 4'hf});
    ins_addr = 32'h200;
    ins_req = 1'b1;
    for (int i = 0; i < 20 && acks == a0; i++) tick();
    tick();
    ins_abort = 1'b1;
    ins_req = 1'b0;
    tick();
    ins_abort = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rv_lat = 1;
    nvec++;
    if (busy !== 1'b0 || iv_cnt != iv0 || acks != a0 + 1) begin
      nfail++;
      $display("FAIL abort: got busy=%b pulses=%0d acks=%0d, required 0 0 1",
               busy, iv_cnt - iv0, acks - a0);
    end
    push_fetch(32'h204);
    ins_addr = 32'h204;
    ins_req = 1'b1;
    drain(40, ok);
    nvec++;
    if (!ok) begin
      nfail++;
      $display("FAIL abort_next_fetch: got pend=%0d, required 0", exp_i.size());
    end
  endtask

  task automatic test_reset_mid();
    int dd0;
    ack_wait = 3;
    dd0 = dd_cnt;
    exp_g.push_back('{1'b0, 32'h500, 32'h0, 4'hf});
    dat_addr = 32'h500;
    dat_wr = 1'b0;
    dat_be = 4'hf;
    dat_req = 1'b1;
    tick();
    tick();
    nvec++;
    if (busy !== 1'b1 || mem.mem_req !== 1'b1) begin
      nfail++;
      $display("FAIL pre_reset: got busy=%b req=%b, required 1 1", busy, mem.mem_req);
    end
    RSTb = 1'b0;
    dat_req = 1'b0;
    #1;
    nvec++;
    if (busy !== 1'b0 || mem.mem_req !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: got busy=%b req=%b, required 0 0", busy, mem.mem_req);
    end
    if (exp_g.size() != 0) void'(exp_g.pop_front());
    ack_wait = 0;
    tick();
    tick();
    RSTb = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    nvec++;
    if (dd_cnt != dd0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_drop: got dones=%0d busy=%b, required 0 0", dd_cnt - dd0, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] be;
    for (int n = 0; n < 10; n++) begin
      kind = int'($urandom_range(0, 2));
      ack_wait = int'($urandom_range(0, 2));
      rv_lat = int'($urandom_range(1, 3));
      a = $urandom;
      d = $urandom;
      be = 4'($urandom_range(1, 15));
      if (a[31:2] == stop_addr[31:2]) a = a ^ 32'h8000_0000;
      if (kind == 0) begin
        push_fetch(a);
        ins_addr = a;
        ins_req = 1'b1;
      end else begin
        if (kind == 1) push_load(a, be);
        else push_store(a, d, be);
        dat_wr = kind == 2;
        dat_addr = a;
        dat_wdata = d;
        dat_be = be;
        dat_req = 1'b1;
      end
      drain(40, ok);
      nvec++;
      if (!ok) begin
        nfail++;
        $display("FAIL b2b_%0d kind=%0d: got pend g=%0d i=%0d d=%0d, required 0",
                 n, kind, exp_g.size(), exp_i.size(), exp_d.size());
      end
    end
    ack_wait = 0;
    rv_lat = 1;
    dat_wr = 1'b0;
  endtask

  task automatic test_starve();
    bit ok;
    stop_cnt = 0;
    dat_stop_after = 5;
    dat_auto_drop = 0;
`ifdef SLURM32_MEM_ARB_FAIR_EN
    for (int i = 0; i < 4; i++) push_load(stop_addr, 4'hf);
    push_fetch(32'h800);
    push_load(stop_addr, 4'hf);
`else
    for (int i = 0; i < 5; i++) push_load(stop_addr, 4'hf);
    push_fetch(32'h800);
`endif
    ins_addr = 32'h800;
    dat_addr = stop_addr;
    dat_wr = 1'b0;
    dat_be = 4'hf;
    ins_req = 1'b1;
    dat_req = 1'b1;
    drain(200, ok);
    dat_auto_drop = 1;
    dat_stop_after = 0;
    nvec++;
    if (!ok || stop_cnt != 5) begin
      nfail++;
      $display("FAIL starve_order: got data_grants=%0d pend=%0d, required 5 0",
               stop_cnt, exp_g.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_store_wait();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_starve();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
